// File: rtl/param_stack_pkg.sv
// Shared definitions for the GET_PARAM parameter stack: control FSM state codes,
// field widths and the packed backtracking entry.
package param_stack_pkg;

    localparam int I_W  = 8;
    localparam int Z_W  = 4;
    localparam int KL_W = 32;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_GET_PARAM  = 3'd1;
    localparam logic [2:0] ST_GET_DATA_1 = 3'd2;
    localparam logic [2:0] ST_GET_DATA_2 = 3'd3;
    localparam logic [2:0] ST_GET_DATA_3 = 3'd4;
    localparam logic [2:0] ST_EX         = 3'd5;
    localparam logic [2:0] ST_WRITE_BACK = 3'd6;
    localparam logic [2:0] ST_DONE       = 3'd7;

    typedef struct packed {
        logic [I_W-1:0]  i;
        logic [Z_W-1:0]  z;
        logic [KL_W-1:0] k;
        logic [KL_W-1:0] l;
    } entry_t;

endpackage

// File: rtl/param_stack_if.sv
// Push bus from EX/WRITE_BACK and popped-parameter bus toward the control FSM.
interface param_stack_if;
    import param_stack_pkg::*;

    logic            push_valid;
    logic [I_W-1:0]  push_i;
    logic [Z_W-1:0]  push_z;
    logic [KL_W-1:0] push_k;
    logic [KL_W-1:0] push_l;

    logic            is_find;
    logic            is_finish;
    logic [I_W-1:0]  param_i;
    logic [Z_W-1:0]  param_z;
    logic [KL_W-1:0] param_k;
    logic [KL_W-1:0] param_l;

    modport master (
        output push_valid, push_i, push_z, push_k, push_l,
        input  is_find, is_finish, param_i, param_z, param_k, param_l
    );

    modport slave (
        input  push_valid, push_i, push_z, push_k, push_l,
        output is_find, is_finish, param_i, param_z, param_k, param_l
    );

endinterface

// File: rtl/param_stack_lifo_mem.sv
// Entry storage for the parameter stack: one synchronous write port and a
// combinational read port; pointer management lives in the parent.
module lifo_mem
    import param_stack_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  entry_t        wr_data,
    input  logic [AW-1:0] rd_addr,
    output entry_t        rd_data
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_stack.sv
// LIFO of pending backtracking entries {i, z, k, l}; pops one entry per GET_PARAM
// visit and flags completion once the stack has drained after a seed.
module param_stack
    import param_stack_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               state,
    input  logic                     is_start,
    input  logic [I_W-1:0]           init_i,
    input  logic [Z_W-1:0]           init_z,
    input  logic [KL_W-1:0]          init_l,
    param_stack_if.slave             bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     push_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic          started;
    logic          is_find_q;
    logic          is_finish_q;
    entry_t        param_q;

    logic          seed_en;
    logic          push_win;
    logic          push_en;
    logic          ovf_hit;
    logic          err_hit;
    logic          pop_en;
    logic          fin_en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    entry_t        wr_entry;
    entry_t        top_entry;

    always_comb begin
        seed_en  = (state == ST_IDLE) && is_start;
        push_win = (state == ST_EX) || (state == ST_WRITE_BACK);
        push_en  = push_win && bus.push_valid && !is_finish_q && (count != FULL);
        ovf_hit  = push_win && bus.push_valid && !is_finish_q && (count == FULL);
        err_hit  = !push_win && bus.push_valid;
        // is_find gating keeps the second GET_PARAM cycle from popping or finishing
        pop_en   = (state == ST_GET_PARAM) && !is_find_q && !is_finish_q && (count != '0);
        fin_en   = (state == ST_GET_PARAM) && started && !is_find_q && (count == '0);

        wr_en    = seed_en || push_en;
        wr_addr  = seed_en ? '0 : count[AW-1:0];
        rd_addr  = AW'(count - CW'(1));

        wr_entry = '0;
        if (seed_en) begin
            wr_entry.i = init_i;
            wr_entry.z = init_z;
            wr_entry.k = '0;
            wr_entry.l = init_l;
        end else begin
            wr_entry.i = bus.push_i;
            wr_entry.z = bus.push_z;
            wr_entry.k = bus.push_k;
            wr_entry.l = bus.push_l;
        end
    end

    lifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_entry),
        .rd_addr (rd_addr),
        .rd_data (top_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            started     <= 1'b0;
            is_find_q   <= 1'b0;
            is_finish_q <= 1'b0;
            param_q     <= '0;
            overflow    <= 1'b0;
            push_err    <= 1'b0;
        end else begin
            is_find_q <= pop_en;

            if (seed_en) begin
                count   <= CW'(1);
                started <= 1'b1;
            end else if (push_en) begin
                count <= count + CW'(1);
            end else if (pop_en) begin
                count <= count - CW'(1);
            end

            if (pop_en) begin
                param_q <= top_entry;
            end
            if (fin_en) begin
                is_finish_q <= 1'b1;
            end
            if (ovf_hit) begin
                overflow <= 1'b1;
            end
            if (err_hit) begin
                push_err <= 1'b1;
            end
        end
    end

    assign bus.is_find   = is_find_q;
    assign bus.is_finish = is_finish_q;
    assign bus.param_i   = param_q.i;
    assign bus.param_z   = param_q.z;
    assign bus.param_k   = param_q.k;
    assign bus.param_l   = param_q.l;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack: seed/pop, LIFO order, illegal push, finish,
// asynchronous reset and overflow, with hand-computed expectations.
module tb_param_stack;
    import param_stack_pkg::*;

    logic            clk;
    logic            rst_n;
    logic [2:0]      state;
    logic            is_start;
    logic [I_W-1:0]  init_i;
    logic [Z_W-1:0]  init_z;
    logic [KL_W-1:0] init_l;
    logic [4:0]      count;
    logic            overflow;
    logic            push_err;

    int n_cmp = 0;
    int n_err = 0;

    param_stack_if ps_if ();

    param_stack #(.DEPTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .state    (state),
        .is_start (is_start),
        .init_i   (init_i),
        .init_z   (init_z),
        .init_l   (init_l),
        .bus      (ps_if),
        .count    (count),
        .overflow (overflow),
        .push_err (push_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [7:0] i, input logic [3:0] z,
                        input logic [31:0] k, input logic [31:0] l);
        state            = st;
        ps_if.push_valid = 1'b1;
        ps_if.push_i     = i;
        ps_if.push_z     = z;
        ps_if.push_k     = k;
        ps_if.push_l     = l;
        step();
        ps_if.push_valid = 1'b0;
    endtask

    function automatic logic [79:0] params();
        return {4'd0, ps_if.param_i, ps_if.param_z, ps_if.param_k, ps_if.param_l};
    endfunction

    function automatic logic [79:0] ent(input logic [7:0] i, input logic [3:0] z,
                                        input logic [31:0] k, input logic [31:0] l);
        return {4'd0, i, z, k, l};
    endfunction

    initial begin
        rst_n            = 1'b0;
        state            = ST_IDLE;
        is_start         = 1'b0;
        init_i           = '0;
        init_z           = '0;
        init_l           = '0;
        ps_if.push_valid = 1'b0;
        ps_if.push_i     = '0;
        ps_if.push_z     = '0;
        ps_if.push_k     = '0;
        ps_if.push_l     = '0;

        // reset state
        #2;
        chk("rst_count",     80'(count), 80'd0);
        chk("rst_is_find",   80'(ps_if.is_find), 80'd0);
        chk("rst_is_finish", 80'(ps_if.is_finish), 80'd0);
        chk("rst_flags",     80'({overflow, push_err}), 80'd0);
        chk("rst_params",    params(), 80'd0);
        step();
        rst_n = 1'b1;

        // seed then pop
        state    = ST_IDLE;
        is_start = 1'b1;
        init_i   = 8'd35;
        init_z   = 4'd2;
        init_l   = 32'd1000;
        step();
        is_start = 1'b0;
        chk("seed_count", 80'(count), 80'd1);
        state = ST_GET_PARAM;
        step();
        chk("seed_pop_find",   80'(ps_if.is_find), 80'd1);
        chk("seed_pop_params", params(), ent(8'd35, 4'd2, 32'd0, 32'd1000));
        chk("seed_pop_count",  80'(count), 80'd0);
        step();
        chk("seed_find_pulse", 80'(ps_if.is_find), 80'd0);
        chk("seed_no_finish",  80'(ps_if.is_finish), 80'd0);

        // LIFO order plus an illegal push in between
        push(ST_WRITE_BACK, 8'd10, 4'd1, 32'd5, 32'd9);
        chk("lifo_count1", 80'(count), 80'd1);
        push(ST_WRITE_BACK, 8'd11, 4'd0, 32'd6, 32'd7);
        chk("lifo_count2", 80'(count), 80'd2);
        push(ST_GET_DATA_1, 8'd99, 4'd3, 32'd1, 32'd2);
        chk("illegal_count",    80'(count), 80'd2);
        chk("illegal_push_err", 80'(push_err), 80'd1);
        state = ST_GET_PARAM;
        step();
        chk("lifo_pop1",       params(), ent(8'd11, 4'd0, 32'd6, 32'd7));
        chk("lifo_pop1_count", 80'(count), 80'd1);
        state = ST_GET_DATA_2;
        step();
        chk("lifo_hold",       params(), ent(8'd11, 4'd0, 32'd6, 32'd7));
        state = ST_GET_PARAM;
        step();
        chk("lifo_pop2",       params(), ent(8'd10, 4'd1, 32'd5, 32'd9));
        chk("lifo_pop2_find",  80'(ps_if.is_find), 80'd1);
        state = ST_EX;
        step();

        // finish after drain
        state = ST_GET_PARAM;
        step();
        chk("finish_set",     80'(ps_if.is_finish), 80'd1);
        chk("finish_no_find", 80'(ps_if.is_find), 80'd0);
        step();
        chk("finish_sticky",  80'(ps_if.is_finish), 80'd1);
        push(ST_WRITE_BACK, 8'd1, 4'd1, 32'd1, 32'd1);
        chk("finish_push_inhibit", 80'(count), 80'd0);
        chk("finish_still",        80'(ps_if.is_finish), 80'd1);

        // asynchronous reset while count=3 and is_find is high
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        state    = ST_IDLE;
        is_start = 1'b1;
        init_i   = 8'd7;
        init_z   = 4'd1;
        init_l   = 32'd50;
        step();
        is_start = 1'b0;
        push(ST_EX, 8'd20, 4'd2, 32'd3, 32'd4);
        push(ST_EX, 8'd21, 4'd3, 32'd5, 32'd6);
        push(ST_EX, 8'd22, 4'd4, 32'd7, 32'd8);
        chk("ar_count4", 80'(count), 80'd4);
        state = ST_GET_PARAM;
        step();
        chk("ar_pop",    params(), ent(8'd22, 4'd4, 32'd7, 32'd8));
        chk("ar_count3", 80'(count), 80'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_count_now",  80'(count), 80'd0);
        chk("ar_find_now",   80'(ps_if.is_find), 80'd0);
        chk("ar_finish_now", 80'(ps_if.is_finish), 80'd0);
        chk("ar_params_now", params(), 80'd0);
        step();
        rst_n = 1'b1;
        state = ST_GET_PARAM;
        step();
        step();
        step();
        chk("ar_unseeded_find",   80'(ps_if.is_find), 80'd0);
        chk("ar_unseeded_finish", 80'(ps_if.is_finish), 80'd0);
        chk("ar_unseeded_count",  80'(count), 80'd0);

        // overflow: 17 pushes into a 16-deep stack
        for (int j = 0; j < 17; j++) begin
            push((j % 2 == 1) ? ST_WRITE_BACK : ST_EX, 8'(j + 1), 4'(j), 32'(100 + j), 32'(200 + j));
            if (j == 15) begin
                chk("ovf_full_count",  80'(count), 80'd16);
                chk("ovf_not_yet",     80'(overflow), 80'd0);
            end
        end
        chk("ovf_count",    80'(count), 80'd16);
        chk("ovf_flag",     80'(overflow), 80'd1);
        chk("ovf_push_err", 80'(push_err), 80'd0);
        state = ST_GET_PARAM;
        step();
        chk("ovf_top",       params(), ent(8'd16, 4'd15, 32'd115, 32'd215));
        chk("ovf_pop_count", 80'(count), 80'd15);
        state = ST_GET_DATA_1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
